// File: rtl/fft_pkg.sv
// Shared types and width helpers for the radix-2 FFT butterfly sequencer.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_LOG2N  = 4;
  localparam int DEF_RD_LAT = 2;

  // Width of the stage index (holds 0..LOG2N-1).
  function automatic int stage_w(input int log2n);
    return $clog2(log2n);
  endfunction

  // Width of the twiddle ROM index (N/2 entries).
  function automatic int tw_w(input int log2n);
    return log2n - 1;
  endfunction

  // Butterflies per stage.
  function automatic int half_n(input int log2n);
    return 1 << (log2n - 1);
  endfunction

  // Width of the drain counter (holds 0..RD_LAT).
  function automatic int cnt_w(input int rd_lat);
    return $clog2(rd_lat + 1);
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage s, butterfly j) to the
// two leg addresses and the twiddle ROM index.
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOG2N = DEF_LOG2N
) (
  input  logic [stage_w(LOG2N)-1:0] s,
  input  logic [LOG2N-2:0]          j,
  output logic [LOG2N-1:0]          rd_addr_a,
  output logic [LOG2N-1:0]          rd_addr_b,
  output logic [LOG2N-2:0]          tw_addr
);

  localparam int AW = LOG2N;
  localparam int TW = tw_w(LOG2N);

  logic [AW-1:0] j_ext;
  logic [AW-1:0] span;
  logic [AW-1:0] pos;

  // Split j into block index (upper bits) and position inside the block;
  // the block index is spread by one bit to make room for the lower leg.
  always_comb begin
    j_ext     = {1'b0, j};
    span      = AW'(1) << s;
    pos       = j_ext & (span - AW'(1));
    rd_addr_a = ((j_ext >> s) << (int'(s) + 1)) | pos;
    rd_addr_b = rd_addr_a + span;
    tw_addr   = TW'(pos << (LOG2N - 1 - int'(s)));
  end

endmodule

// File: rtl/fft_bfly_ctrl.sv
// In-place radix-2 DIT FFT sequencer: walks every stage and butterfly,
// issues read/twiddle addresses, and replays each read address RD_LAT
// cycles later as the write-back address. A drain gap of RD_LAT cycles
// between stages keeps the next stage's reads behind the last writes.
//
// Handshake: start is a level sampled only in IDLE (no ready); done is a
// single-cycle pulse; rd_en/wr_en are strobes with no backpressure.
module fft_bfly_ctrl
  import fft_pkg::*;
#(
  parameter int LOG2N  = DEF_LOG2N,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [LOG2N-1:0]          rd_addr_a,
  output logic [LOG2N-1:0]          rd_addr_b,
  output logic [LOG2N-2:0]          tw_addr,
  output logic                      wr_en,
  output logic [LOG2N-1:0]          wr_addr_a,
  output logic [LOG2N-1:0]          wr_addr_b,
  output logic [stage_w(LOG2N)-1:0] stage
);

  localparam int SW   = stage_w(LOG2N);
  localparam int JW   = LOG2N - 1;
  localparam int CW   = cnt_w(RD_LAT);
  localparam int LW   = 1 + 2 * LOG2N;
  localparam int HALF = half_n(LOG2N);

  state_t         state_q, state_d;
  logic [SW-1:0]  s_q, s_d;
  logic [JW-1:0]  j_q, j_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic           busy_d, done_d, rd_en_d;
  logic [LOG2N-1:0] rd_a_d, rd_b_d;
  logic [JW-1:0]  tw_d;
  logic [SW-1:0]  stage_d;

  logic [LOG2N-1:0] gen_a, gen_b;
  logic [JW-1:0]  gen_tw;

  // Write-back shift line of {valid, addr_a, addr_b}; last entry drives wr_*.
  logic [LW-1:0]  line_q [RD_LAT];

  fft_addr_gen #(.LOG2N(LOG2N)) u_addr_gen (
    .s         (s_q),
    .j         (j_q),
    .rd_addr_a (gen_a),
    .rd_addr_b (gen_b),
    .tw_addr   (gen_tw)
  );

  // Next state, counters and next registered outputs.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    j_d     = j_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    rd_en_d = 1'b0;
    rd_a_d  = '0;
    rd_b_d  = '0;
    tw_d    = '0;
    stage_d = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          s_d     = '0;
          j_d     = '0;
        end
      end
      RUN: begin
        busy_d  = 1'b1;
        stage_d = s_q;
        rd_en_d = 1'b1;
        rd_a_d  = gen_a;
        rd_b_d  = gen_b;
        tw_d    = gen_tw;
        if (j_q == JW'(HALF - 1)) begin
          state_d = DRAIN;
          cnt_d   = CW'(RD_LAT);
        end else begin
          j_d = j_q + JW'(1);
        end
      end
      DRAIN: begin
        busy_d  = 1'b1;
        stage_d = s_q;
        if (cnt_q == CW'(1)) begin
          if (s_q == SW'(LOG2N - 1)) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            s_d     = s_q + SW'(1);
            j_d     = '0;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        s_d     = '0;
        j_d     = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and read-side output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_q       <= '0;
      j_q       <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
      stage     <= '0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      j_q       <= j_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      rd_en     <= rd_en_d;
      rd_addr_a <= rd_a_d;
      rd_addr_b <= rd_b_d;
      tw_addr   <= tw_d;
      stage     <= stage_d;
    end
  end

  // Delay line: shifts every cycle in every state, cleared on reset so no
  // stale write-back survives it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= {rd_en, rd_addr_a, rd_addr_b};
      for (int i = 1; i < RD_LAT; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign {wr_en, wr_addr_a, wr_addr_b} = line_q[RD_LAT-1];

endmodule
